// File: rtl/shift_engine.sv
// shift_engine: parallel-load shift register with a multi-bit shift sequencer.
// A word is loaded in IDLE, then a start shifts it one bit per clock for a
// saturated count in one of four modes, ending with a single-cycle done pulse.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LP_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dout;
  logic             r_ser_out;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_start_go;
  logic [WIDTH:0]   w_shifted;

  // One single-bit shift step; result is {bit shifted out, new register word}.
  function automatic logic [WIDTH:0] f_shift(input logic [WIDTH-1:0] d,
                                             input logic [1:0]       m,
                                             input logic             s);
    logic [WIDTH:0] r;
    case (m)
      2'b00:   r = {d[WIDTH-1], d[WIDTH-2:0], s};
      2'b01:   r = {d[0], s, d[WIDTH-1:1]};
      2'b10:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      default: r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Requests beyond the register width collapse to a full-width shift.
  assign w_cnt_sat  = (count > LP_WIDTH) ? LP_WIDTH : count;
  // Load wins over start; start is only honoured from IDLE.
  assign w_start_go = (r_state == S_IDLE) && start && !load;
  assign w_shifted  = f_shift(r_dout, r_mode, ser_in);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: SHIFT runs until the last remaining shift, DONE lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_go) w_next = (w_cnt_sat != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (r_rem <= LP_ONE) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load / latch sequence parameters in IDLE, shift once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_ser_out <= 1'b0;
      r_rem     <= '0;
      r_mode    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_dout <= din;
          end else if (start) begin
            r_mode <= mode;
            r_rem  <= w_cnt_sat;
          end
        end
        S_SHIFT: begin
          r_dout    <= w_shifted[WIDTH-1:0];
          r_ser_out <= w_shifted[WIDTH];
          r_rem     <= r_rem - LP_ONE;
        end
        default: ;
      endcase
    end
  end

  assign dout    = r_dout;
  assign ser_out = r_ser_out;

endmodule

// File: tb/tb_shift_engine.sv
// Testbench for shift_engine: directed cases plus randomized sequences checked
// against an arithmetic reference model of the shift rules.
module tb_shift_engine;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [1:0]       mode;
  logic             ser_in;
  logic [WIDTH-1:0] dout;
  logic             ser_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_dout = 0;
  int m_ser  = 0;

  shift_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .din     (din),
    .start   (start),
    .count   (count),
    .mode    (mode),
    .ser_in  (ser_in),
    .dout    (dout),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference shift written as plain arithmetic on an 8-bit unsigned value.
  task automatic m_shift(input int m, input int s);
    int d;
    d = m_dout;
    case (m)
      0: begin m_ser = d / 128; m_dout = (d * 2) % 256 + s; end
      1: begin m_ser = d % 2;   m_dout = d / 2 + s * 128; end
      2: begin m_ser = d / 128; m_dout = (d * 2) % 256 + d / 128; end
      default: begin m_ser = d % 2; m_dout = d / 2 + ((d >= 128) ? 128 : 0); end
    endcase
  endtask

  // Load a word, run one start sequence and check timing and result.
  // sin_fixed < 0 means random ser_in each shift; noise toggles ignored inputs.
  task automatic run_seq(input int d, input int m, input int c, input int sin_fixed,
                         input bit noise);
    int n;
    int s;
    load  = 1'b1;
    din   = WIDTH'(d);
    start = noise ? 1'($urandom % 2) : 1'b0;
    tick;
    load  = 1'b0;
    start = 1'b0;
    m_dout = d;
    chk("load_dout", dout, m_dout);
    chk("load_busy", busy, 0);
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    start = 1'b1;
    mode  = 2'(m);
    count = CNT_W'(c);
    tick;
    start = 1'b0;
    n = (c > WIDTH) ? WIDTH : c;
    for (int i = 0; i < n; i++) begin
      chk("shift_busy", busy, 1);
      chk("shift_done", done, 0);
      s = (sin_fixed < 0) ? int'($urandom % 2) : sin_fixed;
      ser_in = 1'(s);
      if (noise) begin
        load  = 1'($urandom % 2);
        start = 1'($urandom % 2);
        din   = WIDTH'($urandom);
        mode  = 2'($urandom);
        count = CNT_W'($urandom);
      end
      m_shift(m, s);
      tick;
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_dout", dout, m_dout);
    chk("end_ser", ser_out, m_ser);
    if (noise) begin
      load  = 1'b1;
      start = 1'b1;
      din   = WIDTH'(~m_dout);
    end
    tick;
    load  = 1'b0;
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_dout", dout, m_dout);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    din    = '0;
    start  = 1'b0;
    count  = '0;
    mode   = 2'b00;
    ser_in = 1'b0;
    tick;
    tick;
    chk("rst_dout", dout, 0);
    chk("rst_ser", ser_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick;

    // logical left, fill with ones
    run_seq(8'hA5, 0, 3, 1, 1'b0);
    chk("a5_dout", dout, 32'h2F);
    chk("a5_ser", ser_out, 1);

    // arithmetic right and logical right
    run_seq(8'h81, 3, 2, 0, 1'b0);
    chk("81_asr", dout, 32'hE0);
    chk("81_asr_ser", ser_out, 0);
    run_seq(8'h81, 1, 2, 0, 1'b0);
    chk("81_lsr", dout, 32'h20);

    // full rotate restores; over-range count saturates
    run_seq(8'h96, 2, 8, 0, 1'b0);
    chk("96_rot8", dout, 32'h96);
    run_seq(8'h96, 2, 12, 0, 1'b0);
    chk("96_rot12", dout, 32'h96);

    // zero count: done next cycle, dout unchanged
    run_seq(8'h5A, 0, 0, 1, 1'b0);
    chk("cnt0_dout", dout, 32'h5A);

    // load and start together: load wins, no sequence
    load  = 1'b1;
    start = 1'b1;
    din   = 8'h3C;
    count = 4'd3;
    tick;
    load  = 1'b0;
    start = 1'b0;
    chk("ls_dout", dout, 32'h3C);
    chk("ls_busy", busy, 0);
    chk("ls_done", done, 0);
    tick;
    chk("ls_busy2", busy, 0);
    chk("ls_done2", done, 0);
    m_dout = 8'h3C;

    // inputs toggled during SHIFT/DONE are ignored
    run_seq(8'hC3, 0, 5, -1, 1'b1);

    // randomized sequences
    for (int k = 0; k < 40; k++) begin
      run_seq(int'($urandom % 256), int'($urandom % 4), int'($urandom % 16), -1,
              1'($urandom % 2));
    end

    // reset in the middle of a shift sequence
    load = 1'b1;
    din  = 8'h55;
    tick;
    load  = 1'b0;
    start = 1'b1;
    mode  = 2'b00;
    count = 4'd8;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick;
    chk("mrst_dout", dout, 0);
    chk("mrst_ser", ser_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    rst_n = 1'b1;
    tick;
    chk("mrst_busy2", busy, 0);
    chk("mrst_done2", done, 0);
    m_dout = 0;
    m_ser  = 0;

    // sequence after reset still works
    run_seq(8'h0F, 3, 4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
